alm_div_16_pipe: RTL and testbench
==================================

# alm_div_16_pipe

Pipelined approximate logarithmic divider: the division counterpart of the team's 16-bit approximate log multiplier. It shares the same leading-one/truncated-mantissa log conversion, subtracts the logs instead of adding them, and converts the result back to a signed Q16.16 quotient. It accepts one operand pair per cycle through a valid/ready handshake with backpressure. It sits beside the multiplier in the approximate-arithmetic datapath.

## Interface
- M_WIDTH, default 5: kept mantissa bits, including the forced LSB of 1. Legal range 2..15.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operand pair present.
- o_ready  out  1  block accepts operands this cycle.
- i_a  in  16  signed dividend.
- i_b  in  16  signed divisor.
- o_valid  out  1  quotient present.
- i_ready  in  1  downstream accepts the quotient.
- o_q  out  32  signed quotient, Q16.16.
- o_dz  out  1  divide-by-zero flag, qualified by o_valid.
- o_ovf  out  1  saturation flag, qualified by o_valid.

## Operation
- Sign: sign_q = i_a[15] ^ i_b[15].
- Magnitude: |x| is the 16-bit unsigned two's-complement negation, so -32768 maps to 0x8000.
- Characteristic k: index of the leading one of the magnitude, 0..15.
- Fraction: frac = (|x| << (15-k))[14:0].
- Truncated mantissa: x = {frac[14 -: M_WIDTH-1], 1'b1}.
- Log value: L = {k, x}, unsigned, 4+M_WIDTH bits.
- Difference: d = L_a - L_b, signed, 5+M_WIDTH bits.
- Split d: c = d >>> M_WIDTH (arithmetic, floor, range -15..15) and f = d[M_WIDTH-1:0].
- Antilog: mant = {1'b1, f}. Shift s = c + 16 - M_WIDTH. If s ≥ 0, mag = mant << s; otherwise mag = mant >> -s (truncate). mag is 33 bits.
- Sign application: o_q = sign_q ? -mag : mag.
- Saturation:
  - A positive result with mag > 0x7FFFFFFF gives o_q = 0x7FFFFFFF and o_ovf = 1.
  - A negative result with mag > 0x80000000 gives o_q = 0x80000000 and o_ovf = 1.
  - mag = 0x80000000 with a negative sign is exact.
- Divisor zero (takes priority over every other case):
  - o_dz = 1 and o_ovf = 0.
  - o_q = 0x7FFFFFFF if i_a ≥ 0, else 0x80000000.
- Dividend zero with a nonzero divisor: o_q = 0, both flags 0.
- Pipeline stages:
  - S1 registers sign_q, the zero flags, L_a and L_b.
  - S2 registers d, sign_q and the zero flags.
  - S3 registers o_q, o_dz and o_ovf.
  - Each stage has a valid bit. o_valid is the S3 valid bit.

## Timing
- Global stall. Define advance = !o_valid | i_ready.
- o_ready = advance. This is combinational from i_ready and o_valid. There is no combinational path from i_valid.
- When advance = 1:
  - All stages shift.
  - S1 valid loads i_valid.
  - A transfer occurs on the input when i_valid & o_ready, and on the output when o_valid & i_ready.
- When advance = 0: all valid bits and data registers hold.
- Latency: exactly 3 cycles from acceptance to o_valid, with no stalls.
- Throughput: 1 result per cycle.
- Results are returned in acceptance order.
- Bubbles with i_valid = 0 propagate as invalid stages.
- Output stability: while o_valid = 1 and i_ready = 0, o_q, o_dz and o_ovf are stable.
- Reset (asynchronous assert, clocked deassert):
  - All valid bits are 0.
  - o_q = 0, o_dz = 0, o_ovf = 0.
  - o_ready = 1 after reset.
  - Reset mid-stream discards every in-flight operation. Nothing in flight is output after reset is released.
- Data registers are reset to 0. Their data value with valid = 0 is don't-care for checking, but still must be 0 after reset.

## Test plan
All values use M_WIDTH = 5.
- 100 / 10 -> o_q = 0x000A8000 (10.5), o_dz = 0, o_ovf = 0, o_valid asserted 3 cycles after acceptance.
- -100 / 10 -> 0xFFF58000. Then 1 / 3 -> 0x00006000 (0.375).
- 32767 / 0 -> 0x7FFFFFFF with o_dz = 1. -5 / 0 -> 0x80000000 with o_dz = 1. 0 / 5 -> 0 with both flags 0.
- Saturation cases:
  - -32768 / -1 -> 0x7FFFFFFF with o_ovf = 1.
  - -32768 / 1 -> 0x80000000 with o_ovf = 0.
- Backpressure sequence:
  - Stream 6 pairs back-to-back with i_ready = 1.
  - Drop i_ready to 0 for 4 cycles after the first o_valid, then restore it.
  - Required: o_ready = 0 and outputs stable during the stall, all 6 results in order, no loss or duplication.
- Reset mid-stream:
  - Assert i_rst_n = 0 with 3 operations in flight.
  - Required: o_valid drops immediately and no stale result appears after release.
  - The first new operation completes with 3-cycle latency.

Source files
------------

// File: rtl/alm_div_16_pipe_if.sv
// Operand/result handshake bundle for the approximate log divider.
// The slave modport is the divider's view; master is the upstream/downstream side.
interface alm_div_16_pipe_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_q;
  logic        o_dz;
  logic        o_ovf;

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_q, o_dz, o_ovf
  );

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_q, o_dz, o_ovf
  );
endinterface

// File: rtl/alm_div_16_pipe.sv
// Three-stage approximate logarithmic divider: log convert, subtract logs,
// antilog with saturation to signed Q16.16. One global stall for all stages.
module alm_div_16_pipe #(
  parameter int M_WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alm_div_16_pipe_if.slave     bus
);

  localparam int LW = 4 + M_WIDTH;
  localparam int DW = 5 + M_WIDTH;
  localparam logic [6:0] S_OFF = 7'(16 - M_WIDTH);

  // Two's-complement magnitude; 0x8000 stays 0x8000 as an unsigned value.
  function automatic logic [15:0] f_abs16(input logic [15:0] x);
    logic [15:0] r;
    if (x[15]) r = 16'd0 - x;
    else       r = x;
    return r;
  endfunction

  // Leading-one characteristic plus truncated mantissa with forced LSB.
  function automatic logic [LW-1:0] f_log(input logic [15:0] m);
    logic [3:0]  k;
    logic [15:0] sh;
    k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) k = i[3:0];
      else      k = k;
    end
    sh = m << (4'd15 - k);
    return {k, sh[14 -: M_WIDTH-1], 1'b1};
  endfunction

  logic          w_advance;
  logic          r_v1, r_v2, r_v3;
  logic          r_sign1, r_az1, r_bz1;
  logic [LW-1:0] r_la1, r_lb1;
  logic          r_sign2, r_az2, r_bz2;
  logic [DW-1:0] r_d2;
  logic [31:0]   r_q3;
  logic          r_dz3, r_ovf3;

  logic [15:0]   w_mag_a, w_mag_b;
  logic [4:0]    w_c;
  logic [6:0]    w_s, w_neg_s;
  logic [32:0]   w_mant, w_mag, w_neg_mag;
  logic [31:0]   w_q;
  logic          w_dz, w_ovf;

  assign w_advance   = !r_v3 | bus.i_ready;
  assign bus.o_ready = w_advance;
  assign bus.o_valid = r_v3;
  assign bus.o_q     = r_q3;
  assign bus.o_dz    = r_dz3;
  assign bus.o_ovf   = r_ovf3;

  // Operand magnitudes feeding the log conversion.
  always_comb begin
    w_mag_a = f_abs16(bus.i_a);
    w_mag_b = f_abs16(bus.i_b);
  end

  // Antilog of the log difference, then sign, saturation and zero cases.
  always_comb begin
    w_c       = r_d2[DW-1:M_WIDTH];
    w_s       = {{2{w_c[4]}}, w_c} + S_OFF;
    w_neg_s   = 7'd0 - w_s;
    w_mant    = {{(32-M_WIDTH){1'b0}}, 1'b1, r_d2[M_WIDTH-1:0]};
    if (w_s[6]) w_mag = w_mant >> w_neg_s[5:0];
    else        w_mag = w_mant << w_s[5:0];
    w_neg_mag = 33'd0 - w_mag;
    w_q       = 32'd0;
    w_dz      = 1'b0;
    w_ovf     = 1'b0;
    if (r_bz2) begin
      w_dz = 1'b1;
      w_q  = r_sign2 ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (r_az2) begin
      w_q = 32'd0;
    end else if (!r_sign2) begin
      if (w_mag > 33'h0_7FFF_FFFF) begin
        w_q   = 32'h7FFF_FFFF;
        w_ovf = 1'b1;
      end else begin
        w_q = w_mag[31:0];
      end
    end else begin
      // Exactly 2^31 negated is representable, so only strictly larger saturates.
      if (w_mag > 33'h0_8000_0000) begin
        w_q   = 32'h8000_0000;
        w_ovf = 1'b1;
      end else begin
        w_q = w_neg_mag[31:0];
      end
    end
  end

  // Pipeline registers: every stage shifts together on advance, otherwise holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_sign1 <= 1'b0;
      r_az1   <= 1'b0;
      r_bz1   <= 1'b0;
      r_la1   <= '0;
      r_lb1   <= '0;
      r_sign2 <= 1'b0;
      r_az2   <= 1'b0;
      r_bz2   <= 1'b0;
      r_d2    <= '0;
      r_q3    <= 32'd0;
      r_dz3   <= 1'b0;
      r_ovf3  <= 1'b0;
    end else if (w_advance) begin
      r_v1    <= bus.i_valid;
      r_sign1 <= bus.i_a[15] ^ bus.i_b[15];
      r_az1   <= (w_mag_a == 16'd0);
      r_bz1   <= (w_mag_b == 16'd0);
      r_la1   <= f_log(w_mag_a);
      r_lb1   <= f_log(w_mag_b);
      r_v2    <= r_v1;
      r_sign2 <= r_sign1;
      r_az2   <= r_az1;
      r_bz2   <= r_bz1;
      r_d2    <= {1'b0, r_la1} - {1'b0, r_lb1};
      r_v3    <= r_v2;
      r_q3    <= w_q;
      r_dz3   <= w_dz;
      r_ovf3  <= w_ovf;
    end
  end

endmodule

// File: tb/tb_alm_div_16_pipe.sv
// Randomised and directed bench for alm_div_16_pipe against an integer
// reference model, with an in-order scoreboard, latency and stall checks.
module tb_alm_div_16_pipe;
  localparam int M = 5;

  logic clk;
  logic rst_n;
  alm_div_16_pipe_if bus();

  alm_div_16_pipe #(.M_WIDTH(M)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] exp;
    int          cyc;
    int          st;
  } item_t;

  item_t sb[$];
  int    n_checks  = 0;
  int    n_errors  = 0;
  int    cyc       = 0;
  int    stall_cnt = 0;
  int    n_out     = 0;
  int    rdy_mode  = 0;
  bit    prev_hold = 1'b0;
  logic [34:0] prev_out;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log value computed arithmetically: characteristic plus top fraction bits.
  function automatic int logv(input int m);
    int k;
    int t;
    k = 0;
    while ((m >> (k + 1)) != 0) k++;
    t = ((m - (1 << k)) << 15) >> k;
    return k * (1 << M) + ((t >> (16 - M)) * 2 + 1);
  endfunction

  function automatic logic [33:0] ref_div(input int a, input int b);
    bit          neg;
    int          ma, mb, d, f, c, mant, s;
    logic [63:0] mag, nmag;
    neg = (a < 0) ^ (b < 0);
    ma  = (a < 0) ? -a : a;
    mb  = (b < 0) ? -b : b;
    if (mb == 0) return {2'b10, (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
    if (ma == 0) return 34'd0;
    d    = logv(ma) - logv(mb);
    f    = d & ((1 << M) - 1);
    c    = (d - f) / (1 << M);
    mant = (1 << M) + f;
    s    = c + 16 - M;
    if (s >= 0) mag = 64'(mant) << s;
    else        mag = 64'(mant >> (-s));
    if (!neg) begin
      if (mag > 64'h7FFF_FFFF) return {2'b01, 32'h7FFF_FFFF};
      return {2'b00, mag[31:0]};
    end
    if (mag > 64'h8000_0000) return {2'b01, 32'h8000_0000};
    nmag = 64'd0 - mag;
    return {2'b00, nmag[31:0]};
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.i_ready = 1'b1;
      1:       bus.i_ready = ($urandom_range(0, 3) != 0);
      default: bus.i_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      check_val("o_ready", 64'(bus.o_ready), 64'(!bus.o_valid || bus.i_ready));
      if (prev_hold)
        check_val("hold", 64'({bus.o_valid, bus.o_dz, bus.o_ovf, bus.o_q}), 64'(prev_out));
      if (bus.o_valid && bus.i_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check_val("spurious", 64'd1, 64'd0);
        end else begin
          it = sb.pop_front();
          check_val("result", 64'({bus.o_dz, bus.o_ovf, bus.o_q}), 64'(it.exp));
          check_val("latency", 64'(cyc - it.cyc), 64'(3 + stall_cnt - it.st));
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        it.exp = ref_div(int'($signed(bus.i_a)), int'($signed(bus.i_b)));
        it.cyc = cyc;
        it.st  = stall_cnt;
        sb.push_back(it);
      end
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_out  = {bus.o_valid, bus.o_dz, bus.o_ovf, bus.o_q};
      if (prev_hold) stall_cnt++;
    end
    cyc++;
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    bit acc;
    int n;
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_val("send_timeout", 64'd0, 64'd1);
    bus.i_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [33:0] exp);
    int n;
    send(a, b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_valid && n < 10);
    check_val({tag, "_lat"}, 64'(n), 64'd3);
    check_val(tag, 64'({bus.o_dz, bus.o_ovf, bus.o_q}), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] specials [5];
    logic [15:0] ra, rb;
    int          out0;
    specials[0] = 16'h0000;
    specials[1] = 16'h0001;
    specials[2] = 16'hFFFF;
    specials[3] = 16'h8000;
    specials[4] = 16'h7FFF;

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_a     = 16'd0;
    bus.i_b     = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(bus.o_valid), 64'd0);
    check_val("rst_q",     64'(bus.o_q), 64'd0);
    check_val("rst_flags", 64'({bus.o_dz, bus.o_ovf}), 64'd0);
    check_val("rst_ready", 64'(bus.o_ready), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("d100_10",   16'd100,   16'd10, 34'h0_000A_8000);
    run_one("dm100_10",  -16'sd100, 16'd10, 34'h0_FFF5_8000);
    run_one("d1_3",      16'd1,     16'd3,  34'h0_0000_6000);
    run_one("d32767_0",  16'h7FFF,  16'd0,  34'h2_7FFF_FFFF);
    run_one("dm5_0",     -16'sd5,   16'd0,  34'h2_8000_0000);
    run_one("d0_5",      16'd0,     16'd5,  34'h0_0000_0000);
    run_one("dmin_m1",   16'h8000,  16'hFFFF, 34'h1_7FFF_FFFF);
    run_one("dmin_1",    16'h8000,  16'd1,  34'h0_8000_0000);

    // Backpressure: six back-to-back pairs with a 4-cycle output stall.
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(100 * (i + 1)), 16'(i + 3));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.o_valid && n < 20);
        rdy_mode = 2;
        repeat (4) begin
          @(negedge clk);
          check_val("bp_o_ready", 64'(bus.o_ready), 64'd0);
        end
        rdy_mode = 0;
      end
    join
    drain();
    check_val("bp_count", 64'(n_out - out0), 64'd6);

    // Reset with three operations in flight.
    send(16'd1000, 16'd7);
    send(-16'sd2000, 16'd9);
    send(16'd300, -16'sd4);
    rst_n = 1'b0;
    #1;
    check_val("mrst_valid", 64'(bus.o_valid), 64'd0);
    check_val("mrst_out", 64'({bus.o_dz, bus.o_ovf, bus.o_q}), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("mrst_stale", 64'(bus.o_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    run_one("d7_2", 16'd7, 16'd2, 34'h0_0003_8000);

    // Random operands, random gaps, random downstream backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) rb = specials[$urandom_range(0, 4)];
      send(ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
